// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU: opcode values, FSM state
// encoding and small opcode-classification helpers.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_AND  = 4'd2;
    localparam logic [OP_W-1:0] OP_OR   = 4'd3;
    localparam logic [OP_W-1:0] OP_SLTU = 4'd4;
    localparam logic [OP_W-1:0] OP_SLT  = 4'd5;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd6;
    localparam logic [OP_W-1:0] OP_SLL  = 4'd7;
    localparam logic [OP_W-1:0] OP_SRL  = 4'd8;
    localparam logic [OP_W-1:0] OP_SRA  = 4'd9;
    localparam logic [OP_W-1:0] OP_MUL  = 4'd10;
    localparam logic [OP_W-1:0] OP_DIVU = 4'd11;
    localparam logic [OP_W-1:0] OP_REMU = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ops that run on the iterative multiply/divide unit.
    function automatic logic is_iter_op(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    function automatic logic is_div_op(input logic [OP_W-1:0] op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// -----------------------------------------------------------------------------
// alu_muldiv_iter
// Iterative unsigned shift-add multiplier and restoring divider, one
// iteration per clock, WIDTH iterations per operation.
//
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   start       load operands and begin an operation
//   is_div      1 = divide (a / b), 0 = multiply (a * b); sampled on start
//   a, b        operands, sampled on start
//   busy        an operation is in progress
//   done        the final iteration is being computed this cycle; quotient
//               and remainder show the finished values and are valid only
//               while done is high
//   quotient    quotient (divide) or low WIDTH bits of product (multiply)
//   remainder   remainder (divide)
// -----------------------------------------------------------------------------
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             active;
    logic             div_mode;
    logic [CW-1:0]    cnt;
    // acc: product accumulator (MUL) / partial remainder (DIV)
    // q:   multiplier shifting right (MUL) / dividend becoming quotient (DIV)
    // d:   multiplicand shifting left (MUL) / divisor (DIV)
    logic [WIDTH-1:0] acc, q, d;
    logic [WIDTH-1:0] acc_nxt, q_nxt, d_nxt;
    logic [WIDTH:0]   shifted, trial;

    // One iteration of the selected algorithm.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        acc_nxt = acc;
        q_nxt   = q;
        d_nxt   = d;
        shifted = '0;
        trial   = '0;
        if (div_mode) begin
            // Shift the next dividend bit into the partial remainder and try
            // subtracting the divisor; restore when it goes negative.
            shifted = {acc, q[WIDTH-1]};
            trial   = shifted - {1'b0, d};
            if (!trial[WIDTH]) begin
                acc_nxt = trial[WIDTH-1:0];
                q_nxt   = {q[WIDTH-2:0], 1'b1};
            end else begin
                // shifted < d here, so its top bit is always clear
                acc_nxt = shifted[WIDTH-1:0];
                q_nxt   = {q[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (q[0]) begin
                acc_nxt = acc + d;
            end
            q_nxt = q >> 1;
            d_nxt = d << 1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values and simulation matches hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            div_mode <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            q        <= '0;
            d        <= '0;
        end else if (start) begin
            active   <= 1'b1;
            div_mode <= is_div;
            cnt      <= CW'(WIDTH);
            acc      <= '0;
            q        <= a;
            d        <= b;
        end else if (active) begin
            acc <= acc_nxt;
            q   <= q_nxt;
            d   <= d_nxt;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                active <= 1'b0;
            end
        end
    end

    assign busy      = active;
    assign done      = active && (cnt == CW'(1));
    // Outputs expose the post-iteration values so the consumer can register
    // the finished result on the same edge as the last iteration.
    assign quotient  = div_mode ? q_nxt : acc_nxt;
    assign remainder = acc_nxt;

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
// Handshaked ALU with registered result and status flags. Single-cycle ops
// complete in one cycle; MUL/DIVU/REMU run on an iterative unit and hold
// off new requests through in_ready while busy.
//
// Ports:
//   clk, rst_n          clock / asynchronous active-low reset
//   in_valid, in_ready  request handshake; op, a, b captured on acceptance
//   op, a, b            operation code and operands
//   out_valid,out_ready result handshake; result/flags held while stalled
//   result              registered result
//   zero, neg           result == 0, result[WIDTH-1]
//   carry, ovf          ADD carry / SUB borrow and signed overflow
//   dz                  divide by zero (DIVU/REMU with b == 0)
// -----------------------------------------------------------------------------
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             neg,
    output logic             dz
);

    state_t state, state_nxt;

    logic             accept;
    logic             div_by_zero;
    logic             long_op;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   sum, diff;
    logic             add_ovf, sub_ovf;

    logic [WIDTH-1:0] sc_res;
    logic             sc_carry, sc_ovf, sc_dz;

    logic             md_start, md_busy, md_done;
    logic [WIDTH-1:0] md_quo, md_rem, md_res;
    logic             want_rem;

    logic             ld_sc, ld_md;
    logic             ld_en;
    logic [WIDTH-1:0] nxt_res;
    logic             nxt_carry, nxt_ovf, nxt_dz;

    assign accept      = in_valid && in_ready;
    assign shamt       = b[SHW-1:0];
    assign div_by_zero = is_div_op(op) && (b == '0);
    assign long_op     = is_iter_op(op) && !div_by_zero;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    // Overflow: operands agree (ADD) / differ (SUB) in sign and the result
    // sign differs from a.
    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

    // Single-cycle datapath, also producing the divide-by-zero results.
    always_comb begin
        sc_res   = sum[WIDTH-1:0];
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_dz    = 1'b0;
        case (op)
            OP_SUB: begin
                sc_res   = diff[WIDTH-1:0];
                sc_carry = diff[WIDTH];
                sc_ovf   = sub_ovf;
            end
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            // Unsigned a < b is exactly the subtract borrow.
            OP_SLTU: sc_res = WIDTH'(diff[WIDTH]);
            OP_SLT:  sc_res = WIDTH'($signed(a) < $signed(b));
            OP_XOR:  sc_res = a ^ b;
            OP_SLL:  sc_res = a << shamt;
            OP_SRL:  sc_res = a >> shamt;
            OP_SRA:  sc_res = $unsigned($signed(a) >>> shamt);
            OP_MUL:  sc_res = '0;
            OP_DIVU: begin
                sc_res = '1;
                sc_dz  = 1'b1;
            end
            OP_REMU: begin
                sc_res = a;
                sc_dz  = 1'b1;
            end
            default: begin
                // ADD and the unassigned opcodes 13-15
                sc_res   = sum[WIDTH-1:0];
                sc_carry = sum[WIDTH];
                sc_ovf   = add_ovf;
            end
        endcase
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (md_start),
        .is_div    (is_div_op(op)),
        .a         (a),
        .b         (b),
        .busy      (md_busy),
        .done      (md_done),
        .quotient  (md_quo),
        .remainder (md_rem)
    );

    assign md_res = want_rem ? md_rem : md_quo;

    // FSM next state and load strobes.
    always_comb begin
        state_nxt = state;
        ld_sc     = 1'b0;
        ld_md     = 1'b0;
        md_start  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (long_op) begin
                        state_nxt = ST_BUSY;
                        md_start  = 1'b1;
                    end else begin
                        state_nxt = ST_DONE;
                        ld_sc     = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (md_done) begin
                    state_nxt = ST_DONE;
                    ld_md     = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (accept) begin
                        // Back-to-back: same routing as from IDLE.
                        if (long_op) begin
                            state_nxt = ST_BUSY;
                            md_start  = 1'b1;
                        end else begin
                            state_nxt = ST_DONE;
                            ld_sc     = 1'b1;
                        end
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Result/flag source for the next load.
    always_comb begin
        ld_en     = ld_sc || ld_md;
        nxt_res   = sc_res;
        nxt_carry = sc_carry;
        nxt_ovf   = sc_ovf;
        nxt_dz    = sc_dz;
        if (ld_md) begin
            nxt_res   = md_res;
            nxt_carry = 1'b0;
            nxt_ovf   = 1'b0;
            nxt_dz    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            want_rem <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            ovf      <= 1'b0;
            neg      <= 1'b0;
            dz       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (md_start) begin
                want_rem <= (op == OP_REMU);
            end
            if (ld_en) begin
                result <= nxt_res;
                zero   <= (nxt_res == '0);
                carry  <= nxt_carry;
                ovf    <= nxt_ovf;
                neg    <= nxt_res[WIDTH-1];
                dz     <= nxt_dz;
            end
        end
    end

    // The iterator is idle in IDLE/DONE; gating on it keeps a new operation
    // from ever being started on top of one still in flight.
    assign in_ready  = !md_busy &&
                       ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
    assign out_valid = (state == ST_DONE);

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the single-cycle 16-bit datapath ALU.
- Adds signed compare, XOR, shifts, and iterative multiply, divide and remainder.
- Adds a registered result with status flags.
- Sits between the register-read stage and writeback; a multi-cycle op stalls issue through valid/ready.

Parameters:
- WIDTH, 16, operand/result width in bits (>= 4, power of two).
- SHW, $clog2(WIDTH), shift-amount bits taken from b[SHW-1:0].

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block accepts a request this cycle.
- op  input  4  operation code (see Behaviour).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0.
- carry  output  1  ADD carry-out / SUB borrow; 0 for all other ops.
- ovf  output  1  signed overflow for ADD/SUB; 0 for all other ops.
- neg  output  1  result[WIDTH-1].
- dz  output  1  divide by zero (DIVU/REMU with b == 0).

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLTU (unsigned a<b -> 1 else 0), 5 SLT (signed).
  - 6 XOR, 7 SLL, 8 SRL, 9 SRA: shift by b[SHW-1:0]; upper bits of b ignored.
  - 10 MUL (low WIDTH bits of a*b), 11 DIVU (quotient), 12 REMU (remainder).
  - 13-15: treated as ADD, no error flag.
- Reset: state IDLE; in_ready=1; out_valid=0; result=0; all flags=0. An operation in flight when reset asserts is discarded.
- Acceptance: a request is accepted on an edge where in_valid && in_ready. Operands and op are captured at that edge; inputs are don't-care afterwards.
- States:
  - IDLE: in_ready=1.
    - Single-cycle op (0-9, 13-15) accepted -> DONE.
    - MUL/DIVU/REMU with b != 0 -> BUSY, iteration counter = WIDTH.
    - DIVU/REMU with b == 0 -> DONE directly.
  - BUSY: in_ready=0. One iteration per cycle, counter decrements. When the counter reaches 0 on an edge -> DONE.
  - DONE: out_valid=1; result and flags are held stable while out_ready=0.
    - in_ready = out_ready.
    - out_ready && !in_valid -> IDLE.
    - out_ready && in_valid: the new request is accepted on the same edge and follows the IDLE transition rules (back-to-back, no bubble).
- Latency, acceptance edge to out_valid high:
  - 1 cycle for single-cycle ops and divide by zero.
  - WIDTH+1 cycles for MUL/DIVU/REMU (17 at WIDTH=16).
- Throughput: 1 op/cycle for single-cycle ops with out_ready held high.
- Arithmetic and flags:
  - ADD: carry = bit WIDTH of the WIDTH+1-bit sum.
  - SUB: carry = borrow (a < b unsigned).
  - ovf per two's-complement rules.
  - zero and neg are computed from the final result for every op.
  - MUL: shift-add, unsigned, truncated to WIDTH bits.
  - DIVU/REMU: restoring division, unsigned.
  - Divide by zero: DIVU result = all ones, REMU result = a, dz=1.
  - dz=0 for all other ops.
- Boundary cases:
  - SRA of a negative value by WIDTH-1 gives all ones.
  - Shift by 0 passes a unchanged.
  - SLT(0x8000,0x0001) = 1 while SLTU of the same operands = 0.
- out_valid never asserts without a prior acceptance. Exactly one result is produced per accepted request.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams: OP_ADD..OP_REMU, OP_W = 4;
  - state encoding: ST_IDLE, ST_BUSY, ST_DONE.
- Sub-module alu_muldiv_iter implements the iterative shift-add multiply and restoring divide.
  - Interface: start, is_div, a, b, busy, done, quotient/product, remainder.
  - Parametrised by WIDTH.
  - seq_alu contains the FSM, the single-cycle datapath and the flag/result registers.

Test Plan:
- ADD 0xFFFF+0x0001, out_ready=1 -> next cycle out_valid=1, result=0x0000, zero=1, carry=1, ovf=0. ADD 0x7FFF+0x0001 -> 0x8000, ovf=1, neg=1.
- SUB 5-7 -> 0xFFFE, carry=1, neg=1. SLT 0x8000,0x0001 -> 1. SLTU with the same operands -> 0. SRA 0x8000 by 15 -> 0xFFFF. SLL 0x0001 by b=0x0013 -> 0x0008.
- MUL 300*300 -> out_valid exactly 17 cycles after acceptance, result=0x5F90, in_ready=0 throughout BUSY.
- DIVU 100/7 -> 14, REMU 100/7 -> 2, each after 17 cycles. DIVU 0x1234/0 -> 0xFFFF, dz=1, 1-cycle latency. REMU 0x1234/0 -> 0x1234, dz=1.
- Backpressure: hold out_ready=0 for 3 cycles after ADD 1+2 -> result=3 held stable, in_ready=0. Then raise out_ready with in_valid=1, ADD 4+4 -> new request accepted same edge, next cycle result=8, no bubble.
- Pulse rst_n low mid-BUSY of a MUL -> immediately out_valid=0, in_ready=1, result=0, flags=0. No stale result appears after reset deasserts.
